// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds NUM_REQ requesters into a
// single UART transmitter through a one-word output register.
// Optional feature: define UART_ARB_BURST_EN to add per-requester req_last
// and a lock that keeps one owner for a multi-word burst.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
`ifdef UART_ARB_BURST_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0]   NR_W   = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_I = PW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q;
  logic [PW-1:0]          rr_ptr_q;
  logic [PW-1:0]          owner_q;
  logic [DATA_WIDTH-1:0]  tx_data_q;
  logic [NUM_REQ-1:0]     grant_q;
`ifdef UART_ARB_BURST_EN
  logic                   lock_q;
`endif

  logic                   win_found;
  logic [PW-1:0]          win_idx;
  logic [NUM_REQ-1:0]     win_oh;
  logic [DATA_WIDTH-1:0]  win_data;
  logic [PW:0]            scan;

  // Pick the first valid requester at or above rr_ptr, wrapping; a locked
  // burst only ever considers its current owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
`ifdef UART_ARB_BURST_EN
    if (lock_q) begin
      win_found = req_valid[owner_q];
      win_idx   = owner_q;
    end else begin
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (scan >= NR_W) scan = scan - NR_W;
        if (!win_found && req_valid[scan[PW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = scan[PW-1:0];
        end
      end
`ifdef UART_ARB_BURST_EN
    end
`endif
  end

  // Decode the winner into a one-hot vector and mux out its word.
  always_comb begin
    win_oh   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && win_idx == PW'(i)) begin
        win_oh[i] = 1'b1;
        win_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Accept is offered only from an empty output register and never in reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE) req_ready = win_oh;
  end

  // Two-state FSM: IDLE captures the winner's word, BUSY holds it until the
  // transmitter takes it; the pointer moves past the owner once it lets go.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
`ifdef UART_ARB_BURST_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q   <= BUSY;
            tx_data_q <= win_data;
            grant_q   <= win_oh;
            owner_q   <= win_idx;
`ifdef UART_ARB_BURST_EN
            lock_q    <= !req_last[win_idx];
`endif
          end
        end
        BUSY: begin
          if (tx_ready) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifdef UART_ARB_BURST_EN
            if (!lock_q)
`endif
              rr_ptr_q <= (owner_q == LAST_I) ? '0 : owner_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid = (state_q == BUSY);
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  grant;
`ifdef UART_ARB_BURST_EN
  logic [3:0]  req_last;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
`ifdef UART_ARB_BURST_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        txr;
    logic [3:0]  e_rdy;  // combinational, before the edge
    logic        e_tv;   // registered, after the edge
    logic [7:0]  e_td;
    logic [3:0]  e_g;
  } vec_t;

  localparam logic [31:0] D55 = 32'hA3A2_A155;
  localparam logic [31:0] DA  = 32'hA3A2_A1A0;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check req_ready before the edge and registered outputs after.
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; req_valid = v.vld; req_data = v.data; tx_ready = v.txr;
    #1;
    chk({tag, ".req_ready"}, {28'd0, req_ready}, {28'd0, v.e_rdy});
    @(posedge clk);
    #1;
    chk({tag, ".tx_valid"}, {31'd0, tx_valid}, {31'd0, v.e_tv});
    chk({tag, ".tx_data"},  {24'd0, tx_data},  {24'd0, v.e_td});
    chk({tag, ".grant"},    {28'd0, grant},    {28'd0, v.e_g});
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = DA; tx_ready = 1'b0;
`ifdef UART_ARB_BURST_EN
    req_last = 4'hF;
`endif
    // reset state
    tbl[0]  = '{1'b1, 4'hF, DA,  1'b0, 4'h0, 1'b0, 8'h00, 4'h0};
    tbl[1]  = '{1'b1, 4'h0, DA,  1'b0, 4'h0, 1'b0, 8'h00, 4'h0};
    // single requester, 0x55
    tbl[2]  = '{1'b0, 4'h1, D55, 1'b1, 4'h1, 1'b1, 8'h55, 4'h1};
    tbl[3]  = '{1'b0, 4'h0, D55, 1'b1, 4'h0, 1'b0, 8'h55, 4'h0};
    tbl[4]  = '{1'b0, 4'h0, D55, 1'b1, 4'h0, 1'b0, 8'h55, 4'h0};
    // re-reset, then all four continuously valid: 0,1,2,3,0
    tbl[5]  = '{1'b1, 4'hF, DA,  1'b1, 4'h0, 1'b0, 8'h00, 4'h0};
    tbl[6]  = '{1'b0, 4'hF, DA,  1'b1, 4'h1, 1'b1, 8'hA0, 4'h1};
    tbl[7]  = '{1'b0, 4'hF, DA,  1'b1, 4'h0, 1'b0, 8'hA0, 4'h0};
    tbl[8]  = '{1'b0, 4'hF, DA,  1'b1, 4'h2, 1'b1, 8'hA1, 4'h2};
    tbl[9]  = '{1'b0, 4'hF, DA,  1'b1, 4'h0, 1'b0, 8'hA1, 4'h0};
    tbl[10] = '{1'b0, 4'hF, DA,  1'b1, 4'h4, 1'b1, 8'hA2, 4'h4};
    tbl[11] = '{1'b0, 4'hF, DA,  1'b1, 4'h0, 1'b0, 8'hA2, 4'h0};
    tbl[12] = '{1'b0, 4'hF, DA,  1'b1, 4'h8, 1'b1, 8'hA3, 4'h8};
    tbl[13] = '{1'b0, 4'hF, DA,  1'b1, 4'h0, 1'b0, 8'hA3, 4'h0};
    tbl[14] = '{1'b0, 4'hF, DA,  1'b1, 4'h1, 1'b1, 8'hA0, 4'h1};
    tbl[15] = '{1'b0, 4'hF, DA,  1'b1, 4'h0, 1'b0, 8'hA0, 4'h0};
    // rr_ptr=1: grant 2 -> rr_ptr=3, only req 1 valid -> wrap to 1 -> rr_ptr=2
    tbl[16] = '{1'b0, 4'h4, DA,  1'b1, 4'h4, 1'b1, 8'hA2, 4'h4};
    tbl[17] = '{1'b0, 4'h0, DA,  1'b1, 4'h0, 1'b0, 8'hA2, 4'h0};
    tbl[18] = '{1'b0, 4'h2, DA,  1'b1, 4'h2, 1'b1, 8'hA1, 4'h2};
    tbl[19] = '{1'b0, 4'h0, DA,  1'b1, 4'h0, 1'b0, 8'hA1, 4'h0};
    tbl[20] = '{1'b0, 4'hF, DA,  1'b0, 4'h4, 1'b1, 8'hA2, 4'h4};
    tbl[21] = '{1'b0, 4'hF, DA,  1'b0, 4'h0, 1'b1, 8'hA2, 4'h4};

    for (int i = 0; i < 22; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // backpressure: 10 more cycles held, then handshake on first tx_ready
    for (int i = 0; i < 10; i++)
      apply('{1'b0, 4'hF, DA, 1'b0, 4'h0, 1'b1, 8'hA2, 4'h4}, $sformatf("bp%0d", i));
    apply('{1'b0, 4'hF, DA, 1'b1, 4'h0, 1'b0, 8'hA2, 4'h0}, "bp_hs");

    // reset mid-BUSY: rr_ptr=3 -> grant 3, then reset discards it
    apply('{1'b0, 4'hF, DA, 1'b0, 4'h8, 1'b1, 8'hA3, 4'h8}, "mr_busy");
    apply('{1'b1, 4'hF, DA, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0}, "mr_rst");
    apply('{1'b0, 4'h6, DA, 1'b0, 4'h2, 1'b1, 8'hA1, 4'h2}, "mr_lowest");
    apply('{1'b0, 4'h0, DA, 1'b1, 4'h0, 1'b0, 8'hA1, 4'h0}, "mr_hs");

`ifdef UART_ARB_BURST_EN
    // burst: req 2 sends B1,B2,B3 (last on third) while req 0 waits
    req_last = 4'h0;
    apply('{1'b1, 4'h0, DA,           1'b0, 4'h0, 1'b0, 8'h00, 4'h0}, "bu_rst");
    apply('{1'b0, 4'h4, 32'hA3B1A1A0, 1'b0, 4'h4, 1'b1, 8'hB1, 4'h4}, "bu_w1");
    apply('{1'b0, 4'h5, 32'hA3B1A1A0, 1'b1, 4'h0, 1'b0, 8'hB1, 4'h0}, "bu_h1");
    apply('{1'b0, 4'h5, 32'hA3B2A1A0, 1'b0, 4'h4, 1'b1, 8'hB2, 4'h4}, "bu_w2");
    apply('{1'b0, 4'h5, 32'hA3B2A1A0, 1'b1, 4'h0, 1'b0, 8'hB2, 4'h0}, "bu_h2");
    req_last = 4'h4;
    apply('{1'b0, 4'h5, 32'hA3B3A1A0, 1'b0, 4'h4, 1'b1, 8'hB3, 4'h4}, "bu_w3");
    apply('{1'b0, 4'h5, 32'hA3B3A1A0, 1'b1, 4'h0, 1'b0, 8'hB3, 4'h0}, "bu_h3");
    apply('{1'b0, 4'h5, 32'hA3B3A1A0, 1'b0, 4'h1, 1'b1, 8'hA0, 4'h1}, "bu_r0");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
